mem_ctrl: RTL

//  Memory controller: responder to the load/store buffer's request port and the instruction-fetch port.

---
 rtl/mem_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Memory controller: serialises LSB load/store requests and instruction fetches
// into byte accesses on the single 8-bit RAM/IO port.
module mem_ctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jp_wrong,
    input  logic        val_flag_MC,
    input  logic [2:0]  insty_MC,
    input  logic [31:0] addr_out,
    input  logic [31:0] val_out,
    output logic        val_flag,
    output logic [31:0] val_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {IDLE, LSB_RD, LSB_WR, IF_RD, DONE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  insty_q, insty_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        val_flag_q, val_flag_d;
    logic [31:0] val_in_q, val_in_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;

    logic        io_stall;
    logic [1:0]  next_idx;
    logic [31:0] word;
    logic [31:0] load_ext;
    logic        lsb_store;

    // Index of the final byte: 0 for byte ops, 1 for halfwords, 3 for words.
    function automatic logic [1:0] last_idx(input logic [2:0] t);
        case (t)
            3'b000, 3'b011, 3'b101: last_idx = 2'd0;
            3'b001, 3'b100, 3'b110: last_idx = 2'd1;
            default:                last_idx = 2'd3;
        endcase
    endfunction

    assign io_stall  = mem_wr_q && (mem_a_q[17:16] == IO_SEL) && io_buffer_full;
    assign lsb_store = insty_MC[2] && (insty_MC[1] || insty_MC[0]);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        insty_d    = insty_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        val_flag_d = val_flag_q;
        val_in_d   = val_in_q;
        if_done_d  = if_done_q;
        if_data_d  = if_data_q;

        next_idx = cnt_q + 2'd1;
        word     = rbuf_q;
        word[{cnt_q, 3'b000} +: 8] = mem_din;

        case (insty_q)
            3'b000:  load_ext = {{24{word[7]}}, word[7:0]};
            3'b001:  load_ext = {{16{word[15]}}, word[15:0]};
            3'b011:  load_ext = {24'b0, word[7:0]};
            3'b100:  load_ext = {16'b0, word[15:0]};
            default: load_ext = word;
        endcase

        if (rdy) begin
            val_flag_d = 1'b0;
            if_done_d  = 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (!jp_wrong && val_flag_MC) begin
                        insty_d  = insty_MC;
                        addr_d   = addr_out;
                        wdata_d  = val_out;
                        last_d   = last_idx(insty_MC);
                        cnt_d    = 2'd0;
                        rbuf_d   = 32'b0;
                        mem_a_d  = addr_out;
                        if (lsb_store) begin
                            state_d    = LSB_WR;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = val_out[7:0];
                        end else begin
                            state_d = LSB_RD;
                        end
                    end else if (!jp_wrong && if_req) begin
                        state_d = IF_RD;
                        addr_d  = if_addr;
                        last_d  = 2'd3;
                        cnt_d   = 2'd0;
                        rbuf_d  = 32'b0;
                        mem_a_d = if_addr;
                    end
                end
                LSB_RD, IF_RD: begin
                    if (jp_wrong) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end else if (cnt_q == last_q) begin
                        state_d = DONE;
                        cnt_d   = 2'd0;
                        if (state_q == IF_RD) begin
                            if_data_d = word;
                            if_done_d = 1'b1;
                        end else begin
                            val_in_d   = load_ext;
                            val_flag_d = 1'b1;
                        end
                    end else begin
                        rbuf_d  = word;
                        cnt_d   = next_idx;
                        mem_a_d = addr_q + {30'b0, next_idx};
                    end
                end
                LSB_WR: begin
                    // Stores ignore jp_wrong; a stalled IO byte simply waits.
                    if (!io_stall) begin
                        if (cnt_q == last_q) begin
                            state_d    = DONE;
                            cnt_d      = 2'd0;
                            mem_wr_d   = 1'b0;
                            val_in_d   = 32'b0;
                            val_flag_d = 1'b1;
                        end else begin
                            cnt_d      = next_idx;
                            mem_a_d    = addr_q + {30'b0, next_idx};
                            mem_dout_d = wdata_q[{next_idx, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            insty_q    <= 3'b0;
            rbuf_q     <= 32'b0;
            mem_a_q    <= 32'b0;
            mem_dout_q <= 8'b0;
            mem_wr_q   <= 1'b0;
            val_flag_q <= 1'b0;
            val_in_q   <= 32'b0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            insty_q    <= insty_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            val_flag_q <= val_flag_d;
            val_in_q   <= val_in_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
        end
    end

    assign val_flag = val_flag_q;
    assign val_in   = val_in_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q && !io_stall;

endmodule
